// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared types for the ALU scheduling slice: the data word, the ALU opcode
// encodings, the operation bundle a requester presents (alu_req_t), the
// result flag bundle and the output-stage state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package isa_pkg;

  typedef logic [31:0] word_t;

  // Tag width carried inside alu_req_t. The scheduler's TAGW parameter
  // defaults to this; a narrower TAGW keeps the low bits, a wider one
  // zero-extends.
  localparam int TAG_W = 5;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_SRA  = 4'h2,
    ALU_ADD  = 4'h3,
    ALU_SUB  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_XOR  = 4'h7,
    ALU_NOR  = 4'h8,
    ALU_SLT  = 4'h9,
    ALU_SLTU = 4'hA
  } aluop_t;

  typedef struct packed {
    aluop_t             aluop;
    word_t              port_a;
    word_t              port_b;
    logic [TAG_W-1:0]   tag;
  } alu_req_t;

  // Bit order matches out_flags: {negative, overflow, zero}.
  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
  } alu_flags_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/fu_alu_if.sv
// -----------------------------------------------------------------------------
// fu_alu_if
// Bundle between the scheduler and the shared combinational ALU.
//   sched modport : drives operands, reads results
//   alu   modport : reads operands, drives results (the ALU side)
// -----------------------------------------------------------------------------
interface fu_alu_if;
  import isa_pkg::*;

  logic [3:0] aluop;
  word_t      port_a;
  word_t      port_b;
  word_t      port_output;
  logic       negative;
  logic       overflow;
  logic       zero;

  modport sched (
    output aluop, port_a, port_b,
    input  port_output, negative, overflow, zero
  );

  modport alu (
    input  aluop, port_a, port_b,
    output port_output, negative, overflow, zero
  );

endinterface

// File: rtl/fu_alu_port.sv
// -----------------------------------------------------------------------------
// fu_alu_port
// Maps the ALU side of an fu_alu_if onto discrete pins so an external ALU
// can be attached to the scheduler.
//   alu_side        : fu_alu_if.alu modport
//   alu_aluop/a/b   : operands out to the ALU
//   alu_port_output : ALU result in
//   alu_negative/overflow/zero : ALU flags in
// -----------------------------------------------------------------------------
module fu_alu_port (
  fu_alu_if.alu         alu_side,
  output logic [3:0]    alu_aluop,
  output logic [31:0]   alu_port_a,
  output logic [31:0]   alu_port_b,
  input  logic [31:0]   alu_port_output,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic          alu_zero
);

  assign alu_aluop            = alu_side.aluop;
  assign alu_port_a           = alu_side.port_a;
  assign alu_port_b           = alu_side.port_b;

  assign alu_side.port_output = alu_port_output;
  assign alu_side.negative    = alu_negative;
  assign alu_side.overflow    = alu_overflow;
  assign alu_side.zero        = alu_zero;

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set bit of req at or above ptr,
// wrapping to bit 0 when nothing at or above ptr is requesting.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   en    : grant enable; grant is all-zero when low
//   grant : one-hot grant (all-zero when en is low or req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic [N-1:0] w_upper_mask;
  logic [N-1:0] w_upper_req;
  logic [N-1:0] w_pick;
  logic [N-1:0] w_first;
  logic         w_found;

  // Split the search in two: requests at/above ptr win first; if none,
  // fall back to the plain lowest request, which is the wrapped search.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_upper_mask = '0;
    w_first      = '0;
    w_found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_upper_mask[i] = (i >= int'(ptr));
    end
    w_upper_req = req & w_upper_mask;
    w_pick      = (|w_upper_req) ? w_upper_req : req;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i] && !w_found) begin
        w_first[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign grant = en ? w_first : '0;

endmodule

// File: rtl/fu_alu_sched.sv
// -----------------------------------------------------------------------------
// fu_alu_sched
// Shares one combinational ALU among NREQ requesters. Each cycle the output
// register can accept, one valid requester is picked round-robin, its
// operands drive the ALU, and the ALU result plus the request's tag and
// source index are captured into a single-entry output register.
//   CLK, nRST         : clock, asynchronous active-low reset
//   flush             : squash the output register, block grants this cycle
//   req_valid/ready   : per-requester handshake
//   req_op            : per-requester {aluop, port_a, port_b, tag}
//   alu_*             : operands to / results from the external ALU
//   out_valid/ready   : result handshake
//   out_result/flags/tag/src : captured result, {n,v,z}, tag, requester index
//   issue_cnt         : wrapping count of accepted operations
// -----------------------------------------------------------------------------
module fu_alu_sched
  import isa_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int TAGW = TAG_W,
  localparam int SRCW = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  alu_req_t [NREQ-1:0]   req_op,
  output logic [3:0]            alu_aluop,
  output logic [31:0]           alu_port_a,
  output logic [31:0]           alu_port_b,
  input  logic [31:0]           alu_port_output,
  input  logic                  alu_negative,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [2:0]            out_flags,
  output logic [TAGW-1:0]       out_tag,
  output logic [SRCW-1:0]       out_src,
  output logic [15:0]           issue_cnt
);

  out_state_t      r_state;
  word_t           r_out_result;
  alu_flags_t      r_out_flags;
  logic [TAGW-1:0] r_out_tag;
  logic [SRCW-1:0] r_out_src;
  logic [SRCW-1:0] r_rr_ptr;
  logic [15:0]     r_issue_cnt;

  logic            w_accept;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;
  alu_req_t        w_sel;
  logic [SRCW-1:0] w_src;
  logic [SRCW-1:0] w_ptr_next;

  fu_alu_if u_alu_if ();

  // The output register can take a new result when it is empty or being
  // drained this cycle. nRST gates it so no requester sees ready while the
  // block is held in reset.
  assign w_accept = nRST && ((r_state == OUT_EMPTY) || out_ready) && !flush;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .en    (w_accept),
    .grant (w_grant)
  );

  // Grants are only ever issued to valid requesters, so any grant bit is a
  // completed handshake.
  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  // One-hot mux of the granted request; all-zero operands when idle.
  always_comb begin
    w_sel = '0;
    w_src = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel = req_op[i];
        w_src = SRCW'(i);
      end
    end
  end

  assign w_ptr_next = (w_src == SRCW'(NREQ - 1)) ? '0 : w_src + 1'b1;

  assign u_alu_if.aluop  = w_sel.aluop;
  assign u_alu_if.port_a = w_sel.port_a;
  assign u_alu_if.port_b = w_sel.port_b;

  fu_alu_port u_alu_port (
    .alu_side        (u_alu_if.alu),
    .alu_aluop       (alu_aluop),
    .alu_port_a      (alu_port_a),
    .alu_port_b      (alu_port_b),
    .alu_port_output (alu_port_output),
    .alu_negative    (alu_negative),
    .alu_overflow    (alu_overflow),
    .alu_zero        (alu_zero)
  );

  // Output-stage FSM plus the state that moves only on a handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= OUT_EMPTY;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_out_tag    <= '0;
      r_out_src    <= '0;
      r_rr_ptr     <= '0;
      r_issue_cnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (r_state)
        OUT_EMPTY: if (w_hs) r_state <= OUT_FULL;
        OUT_FULL: begin
          if (flush)                  r_state <= OUT_EMPTY;
          else if (!w_hs && out_ready) r_state <= OUT_EMPTY;
        end
        default:                      r_state <= OUT_EMPTY;
      endcase

      if (w_hs) begin
        r_out_result <= u_alu_if.port_output;
        r_out_flags  <= {u_alu_if.negative, u_alu_if.overflow, u_alu_if.zero};
        r_out_tag    <= TAGW'(w_sel.tag);
        r_out_src    <= w_src;
        r_rr_ptr     <= w_ptr_next;
        r_issue_cnt  <= r_issue_cnt + 16'd1;
      end
    end
  end

  assign out_valid  = (r_state == OUT_FULL);
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign out_tag    = r_out_tag;
  assign out_src    = r_out_src;
  assign issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_fu_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_fu_alu_sched
// Directed bench for fu_alu_sched with NREQ=4, TAGW=5. A small combinational
// ALU (ADD/SUB/AND/OR/XOR) stands in for the shared ALU. Inputs change 1 time
// unit after the rising edge; combinational outputs are sampled at the
// falling edge and registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fu_alu_sched;
  import isa_pkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 5;

  logic                CLK;
  logic                nRST;
  logic                flush;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  alu_req_t [NREQ-1:0] req_op;
  logic [3:0]          alu_aluop;
  logic [31:0]         alu_port_a;
  logic [31:0]         alu_port_b;
  logic [31:0]         alu_port_output;
  logic                alu_negative;
  logic                alu_overflow;
  logic                alu_zero;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_result;
  logic [2:0]          out_flags;
  logic [TAGW-1:0]     out_tag;
  logic [1:0]          out_src;
  logic [15:0]         issue_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed results of the standing round-robin ops (ADD 100*(i+1)+i).
  int rr_result [NREQ] = '{100, 201, 302, 403};
  int rr_order  [5]    = '{0, 1, 2, 3, 0};

  fu_alu_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .alu_aluop       (alu_aluop),
    .alu_port_a      (alu_port_a),
    .alu_port_b      (alu_port_b),
    .alu_port_output (alu_port_output),
    .alu_negative    (alu_negative),
    .alu_overflow    (alu_overflow),
    .alu_zero        (alu_zero),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_flags       (out_flags),
    .out_tag         (out_tag),
    .out_src         (out_src),
    .issue_cnt       (issue_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in shared ALU.
  always_comb begin
    alu_port_output = '0;
    alu_overflow    = 1'b0;
    case (alu_aluop)
      ALU_ADD: begin
        alu_port_output = alu_port_a + alu_port_b;
        alu_overflow    = (alu_port_a[31] == alu_port_b[31]) &&
                          (alu_port_output[31] != alu_port_a[31]);
      end
      ALU_SUB: begin
        alu_port_output = alu_port_a - alu_port_b;
        alu_overflow    = (alu_port_a[31] != alu_port_b[31]) &&
                          (alu_port_output[31] != alu_port_a[31]);
      end
      ALU_AND: alu_port_output = alu_port_a & alu_port_b;
      ALU_OR:  alu_port_output = alu_port_a | alu_port_b;
      ALU_XOR: alu_port_output = alu_port_a ^ alu_port_b;
      default: ;
    endcase
    alu_negative = alu_port_output[31];
    alu_zero     = (alu_port_output == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic alu_req_t mk(input aluop_t op, input word_t a,
                                  input word_t b, input logic [TAG_W-1:0] t);
    alu_req_t r;
    r.aluop  = op;
    r.port_a = a;
    r.port_b = b;
    r.tag    = t;
    return r;
  endfunction

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_rr_ops();
    for (int i = 0; i < NREQ; i++)
      req_op[i] = mk(ALU_ADD, 32'(100 * (i + 1)), 32'(i), TAG_W'(i + 4));
  endtask

  // Called 1 unit after an edge; returns 1 unit after the next edge.
  task automatic do_reset();
    nRST      = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2 nRST = 1'b1;
    sync();
  endtask

  // Present one op on requester idx alone, wait (bounded) for its grant,
  // and return 1 unit after the handshake edge with req_valid dropped.
  task automatic issue(input int idx, input alu_req_t op);
    int waited;
    waited       = 0;
    req_op[idx]  = op;
    req_valid    = '0;
    req_valid[idx] = 1'b1;
    #4;
    while (!req_ready[idx] && waited < 20) begin
      sync();
      #4;
      waited++;
    end
    check("issue_grant", req_ready[idx], 1);
    sync();
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got no summary, expected one");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state, no grant during reset ----------------
    nRST      = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = '1;
    load_rr_ops();
    #1 nRST = 1'b0;
    #1;
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags",  out_flags,  0);
    check("rst_out_tag",    out_tag,    0);
    check("rst_out_src",    out_src,    0);
    check("rst_issue_cnt",  issue_cnt,  0);
    check("rst_no_grant",   req_ready,  0);
    req_valid = '0;
    @(posedge CLK);
    #2 nRST = 1'b1;
    sync();

    // ---------------- single request ----------------
    req_op[0] = mk(ALU_ADD, 32'd5, 32'd7, 5'd3);
    req_valid = 4'b0001;
    #4;
    check("single_ready", req_ready,  4'b0001);
    check("single_aluop", alu_aluop,  ALU_ADD);
    check("single_a",     alu_port_a, 5);
    check("single_b",     alu_port_b, 7);
    sync();
    req_valid = '0;
    check("single_valid",  out_valid,  1);
    check("single_result", out_result, 12);
    check("single_tag",    out_tag,    3);
    check("single_src",    out_src,    0);
    check("single_cnt",    issue_cnt,  1);
    #4;
    check("idle_alu_a",    alu_port_a, 0);
    check("idle_aluop",    alu_aluop,  0);
    check("idle_ready",    req_ready,  0);
    sync();
    check("drain_valid",   out_valid,  0);

    // ---------------- round robin, back to back ----------------
    do_reset();
    load_rr_ops();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = rr_order[k];
      #4;
      check("rr_ready", req_ready, 32'(1) << e);
      sync();
      check("rr_valid",  out_valid,  1);
      check("rr_src",    out_src,    e);
      check("rr_result", out_result, rr_result[e]);
      check("rr_tag",    out_tag,    e + 4);
    end
    check("rr_cnt", issue_cnt, 5);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #4;
      check("bp_ready",  req_ready,  0);
      check("bp_valid",  out_valid,  1);
      check("bp_result", out_result, 100);
      check("bp_src",    out_src,    0);
      check("bp_tag",    out_tag,    4);
      sync();
    end
    out_ready = 1'b1;
    #4;
    check("bp_release_ready", req_ready, 4'b0010);
    sync();
    req_valid = '0;
    check("bp_release_src",    out_src,    1);
    check("bp_release_result", out_result, 201);
    check("bp_release_cnt",    issue_cnt,  6);

    // ---------------- flags ----------------
    issue(2, mk(ALU_SUB, 32'd0, 32'd1, 5'd11));
    check("neg_result", out_result, 32'hFFFF_FFFF);
    check("neg_flags",  out_flags,  3'b100);
    check("neg_src",    out_src,    2);
    issue(2, mk(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd12));
    check("ovf_result", out_result, 32'h8000_0000);
    check("ovf_flags",  out_flags,  3'b110);
    issue(2, mk(ALU_SUB, 32'd9, 32'd9, 5'd13));
    check("zero_result", out_result, 0);
    check("zero_flags",  out_flags,  3'b001);
    check("zero_tag",    out_tag,    13);
    issue(0, mk(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd14));
    check("and_result", out_result, 32'h0F00_0F00);
    check("and_flags",  out_flags,  3'b000);
    check("flags_cnt",  issue_cnt,  10);

    // ---------------- flush ----------------
    issue(1, mk(ALU_ADD, 32'd20, 32'd22, 5'd9));
    check("pre_flush_valid",  out_valid,  1);
    check("pre_flush_result", out_result, 42);
    req_op[3] = mk(ALU_ADD, 32'd1, 32'd1, 5'd10);
    req_valid = 4'b1000;
    flush     = 1'b1;
    #4;
    check("flush_no_grant", req_ready,  0);
    check("flush_alu_a",    alu_port_a, 0);
    sync();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_cnt",   issue_cnt, 11);
    req_valid = 4'b1010;
    #4;
    check("flush_ptr_kept", req_ready, 4'b1000);
    sync();
    req_valid = '0;
    check("post_flush_src",    out_src,    3);
    check("post_flush_result", out_result, 2);
    check("post_flush_tag",    out_tag,    10);
    check("post_flush_cnt",    issue_cnt,  12);

    // ---------------- counter wrap, then reset mid-stream ----------------
    do_reset();
    load_rr_ops();
    req_valid = '1;
    repeat (65535) sync();
    check("cnt_ffff", issue_cnt, 16'hFFFF);
    sync();
    check("cnt_wrap", issue_cnt, 0);
    sync();
    check("mid_src",    out_src,    0);
    check("mid_result", out_result, 100);
    nRST = 1'b0;
    #1;
    check("mid_rst_valid",  out_valid,  0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_cnt",    issue_cnt,  1'b0);
    check("mid_rst_ready",  req_ready,  0);
    #1 nRST = 1'b1;
    #2;
    check("mid_rst_ptr", req_ready, 4'b0001);
    sync();
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
